hawk_axird_mc_replay_buf: RTL



---
 rtl/hawk_axird_mc_replay_buf.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hawk_axird_mc_replay_buf.sv
// hawk_axird_mc_replay_buf: multi-channel AXI4 read replay buffer with reserved-space AR gating (HAWK_AXIRD_ERR_CNT_EN adds per-channel error-beat counters)
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
module hawk_axird_mc_replay_buf #(
  parameter int DATA_WIDTH = `HACD_AXI4_DATA_WIDTH,
  parameter int ADDR_WIDTH = `HACD_AXI4_ADDR_WIDTH,
  parameter int ID_WIDTH   = `HACD_AXI4_ID_WIDTH,
  parameter int NUM_CH     = 4,
  parameter int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int DEPTH      = 32,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          m_axi_arid,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [ID_WIDTH-1:0]          m_axi_rid,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_last,
  output logic [NUM_CH*2-1:0]          out_resp,
  input  logic [NUM_CH-1:0]            ch_rewind,
  input  logic [NUM_CH-1:0]            ch_commit,
  output logic [NUM_CH-1:0]            ch_empty,
  output logic [NUM_CH-1:0]            ch_full,
  output logic [NUM_CH*16-1:0]         err_cnt
);
  localparam int MW = DATA_WIDTH + 3;
  // reservation must hold a whole 256-beat burst even when DEPTH is small
  localparam int RW = (CNT_W + 1 > 9) ? CNT_W + 1 : 9;
  localparam logic [CH_BITS-1:0] CH_MASK = CH_BITS'(NUM_CH - 1);
  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} st_e;
  st_e st_q, st_d;
  logic arready_q, arvalid_q, ar_hs, res_go;
  logic [ID_WIDTH-1:0] hid_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [7:0] hlen_q;
  logic [2:0] hsize_q;
  logic [1:0] hburst_q;
  logic [CH_BITS-1:0] hch, wch;
  logic [NUM_CH-1:0] fit;
  logic unused;
  assign unused = ^m_axi_rid;
  assign wch = m_axi_rid[CH_BITS-1:0] & CH_MASK;
  assign hch = hid_q[CH_BITS-1:0] & CH_MASK;
  assign m_axi_rready = !ch_full[wch];
  assign ar_hs = s_axi_arvalid && arready_q;
  assign res_go = st_q == CHECK && fit[hch];
  assign s_axi_arready = arready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arid = hid_q;
  assign m_axi_araddr = haddr_q;
  assign m_axi_arlen = hlen_q;
  assign m_axi_arsize = hsize_q;
  assign m_axi_arburst = hburst_q;
  // AR sequencing: accept one request, wait until its burst fits, then issue
  always_comb begin
    st_d = (st_q == IDLE && ar_hs) ? CHECK : res_go ? ISSUE : (st_q == ISSUE && m_axi_arready) ? IDLE : st_q;
  end
  // AR state, registered handshakes and holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      arready_q <= 1'b0;
      arvalid_q <= 1'b0;
      hid_q <= '0;
      haddr_q <= '0;
      hlen_q <= '0;
      hsize_q <= '0;
      hburst_q <= '0;
    end else begin
      st_q <= st_d;
      arready_q <= st_d == IDLE;
      arvalid_q <= st_d == ISSUE;
      if (ar_hs) begin
        hid_q <= s_axi_arid;
        haddr_q <= s_axi_araddr;
        hlen_q <= s_axi_arlen;
        hsize_q <= s_axi_arsize;
        hburst_q <= s_axi_arburst;
      end
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [MW-1:0] mem_q [DEPTH];
    logic [MW-1:0] od_q;
    logic [CNT_W-1:0] wr_q, rd_q, cm_q, rd_n, rd_d, cm_d, used;
    logic [RW-1:0] resv_q, resv_d;
    logic ov_q, ov_d, we, rew;
    assign fit[g] = resv_q == '0 || 32'(resv_q) + 32'(hlen_q) + 32'd1 <= 32'(DEPTH);
    assign out_valid[g] = ov_q;
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = od_q[DATA_WIDTH-1:0];
    assign out_last[g] = od_q[DATA_WIDTH];
    assign out_resp[g*2 +: 2] = od_q[MW-1 -: 2];
    assign ch_empty[g] = rd_q == wr_q;
    assign ch_full[g] = (wr_q - cm_q) == CNT_W'(DEPTH);
    // pointer moves: pop, rewind (loses to commit), commit, and reservation bookkeeping
    always_comb begin
      we = m_axi_rvalid && m_axi_rready && wch == CH_BITS'(g);
      rew = ch_rewind[g] && !ch_commit[g];
      rd_n = rd_q + CNT_W'(ov_q && out_ready[g]);
      used = rd_n - cm_q;
      rd_d = rew ? cm_q : rd_n;
      cm_d = ch_commit[g] ? rd_n : cm_q;
      ov_d = !rew && rd_n != wr_q;
      resv_d = resv_q + ((res_go && hch == CH_BITS'(g)) ? RW'(hlen_q) + RW'(1) : RW'(0)) - (ch_commit[g] ? RW'(used) : RW'(0));
    end
    // channel state and first-word-fall-through output register
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q <= '0;
        rd_q <= '0;
        cm_q <= '0;
        resv_q <= '0;
        ov_q <= 1'b0;
        od_q <= '0;
      end else begin
        wr_q <= wr_q + CNT_W'(we);
        rd_q <= rd_d;
        cm_q <= cm_d;
        resv_q <= resv_d;
        ov_q <= ov_d;
        od_q <= mem_q[rd_n[CNT_W-2:0]];
      end
    end
    // beat storage, no reset needed since pointers gate every read
    always_ff @(posedge clk) begin
      if (we) mem_q[wr_q[CNT_W-2:0]] <= {m_axi_rresp, m_axi_rlast, m_axi_rdata};
    end
`ifdef HAWK_AXIRD_ERR_CNT_EN
    logic [15:0] ec_q;
    assign err_cnt[g*16 +: 16] = ec_q;
    // saturating count of written beats carrying a non-OKAY response
    always_ff @(posedge clk) begin
      if (rst) ec_q <= '0;
      else if (we && m_axi_rresp != 2'b00 && ec_q != 16'hFFFF) ec_q <= ec_q + 16'd1;
    end
`else
    assign err_cnt[g*16 +: 16] = '0;
`endif
  end
endmodule
